// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI read/write arbiters: master count, master index, FSM states.
package axi_arb_pkg;

    localparam int NUM_M = 4;

    typedef logic [1:0] mst_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // One-hot grant vector for a master index.
    function automatic logic [NUM_M-1:0] idx_to_onehot(input mst_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request bit scanning circularly from ptr.
module rr_pick4
    import axi_arb_pkg::*;
(
    input  logic [3:0] req,
    input  mst_idx_t   ptr,
    output logic       found,
    output mst_idx_t   win
);

    mst_idx_t idx_s;

    // Circular scan ptr, ptr+1, ... keeping the first hit.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx_s = ptr;
        for (int k = 0; k < NUM_M; k++) begin
            idx_s = ptr + mst_idx_t'(k);
            if (!found && req[idx_s]) begin
                found = 1'b1;
                win   = idx_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/axi_arbiter_rd.sv
// Round-robin read-channel arbiter for 4 masters; grant spans AR handshake through RLAST,
// with a watchdog that reclaims the bus from stalled bursts.
module axi_arbiter_rd
    import axi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 9
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       m0_ARVALID,
    input  logic       m1_ARVALID,
    input  logic       m2_ARVALID,
    input  logic       m3_ARVALID,
    input  logic       m0_RREADY,
    input  logic       m1_RREADY,
    input  logic       m2_RREADY,
    input  logic       m3_RREADY,
    input  logic       ARREADY,
    input  logic       RVALID,
    input  logic       RLAST,
    output logic       m0_rgrnt,
    output logic       m1_rgrnt,
    output logic       m2_rgrnt,
    output logic       m3_rgrnt,
    output logic [1:0] rgrnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam bit               WD_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WD_EN ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t       state_r;
    logic [3:0]       grant_r;
    mst_idx_t         id_r;
    mst_idx_t         ptr_r;
    logic             busy_r;
    logic             timeout_r;
    logic [CNT_W-1:0] cnt_r;

    logic [3:0] req_s;
    logic [3:0] rready_s;
    logic       ar_hs_s;
    logic       rbeat_s;
    logic       last_s;
    logic       progress_s;
    logic       wd_exp_s;
    logic [3:0] pick_req_s;
    mst_idx_t   pick_ptr_s;
    logic       found_s;
    mst_idx_t   win_s;

    assign req_s      = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
    assign rready_s   = {m3_RREADY, m2_RREADY, m1_RREADY, m0_RREADY};
    assign ar_hs_s    = req_s[id_r] & ARREADY;
    assign rbeat_s    = RVALID & rready_s[id_r];
    assign last_s     = rbeat_s & RLAST;
    assign progress_s = ar_hs_s | rbeat_s;
    assign wd_exp_s   = WD_EN && (cnt_r == CNT_END) && !progress_s;

    // On a last beat the next winner excludes the current master and scans from g+1.
    always_comb begin
        if (state_r == DATA) begin
            pick_req_s = req_s & ~idx_to_onehot(id_r);
            pick_ptr_s = id_r + 2'd1;
        end else begin
            pick_req_s = req_s;
            pick_ptr_s = ptr_r;
        end
    end

    rr_pick4 u_pick (
        .req   (pick_req_s),
        .ptr   (pick_ptr_s),
        .found (found_s),
        .win   (win_s)
    );

    // Arbitration FSM, watchdog counter and registered outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r   <= IDLE;
            grant_r   <= 4'b0000;
            id_r      <= 2'd0;
            ptr_r     <= 2'd0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r <= idx_to_onehot(win_s);
                        id_r    <= win_s;
                        busy_r  <= 1'b1;
                        state_r <= ADDR;
                        cnt_r   <= '0;
                    end else begin
                        grant_r <= 4'b0000;
                        busy_r  <= 1'b0;
                    end
                end
                ADDR, DATA: begin
                    // A last beat takes precedence over a simultaneous watchdog expiry.
                    if (state_r == DATA && last_s) begin
                        ptr_r <= id_r + 2'd1;
                        cnt_r <= '0;
                        if (found_s) begin
                            grant_r <= idx_to_onehot(win_s);
                            id_r    <= win_s;
                            state_r <= ADDR;
                        end else begin
                            grant_r <= 4'b0000;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else if (wd_exp_s) begin
                        grant_r   <= 4'b0000;
                        busy_r    <= 1'b0;
                        timeout_r <= 1'b1;
                        ptr_r     <= id_r + 2'd1;
                        state_r   <= IDLE;
                        cnt_r     <= '0;
                    end else begin
                        if (state_r == ADDR && ar_hs_s) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= state_r;
                        end
                        if (progress_s) begin
                            cnt_r <= '0;
                        end else if (cnt_r != CNT_MAX) begin
                            cnt_r <= cnt_r + 1'b1;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 4'b0000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign m0_rgrnt = grant_r[0];
    assign m1_rgrnt = grant_r[1];
    assign m2_rgrnt = grant_r[2];
    assign m3_rgrnt = grant_r[3];
    assign rgrnt_id = id_r;
    assign busy     = busy_r;
    assign timeout  = timeout_r;

endmodule

// File: tb/tb_axi_arbiter_rd.sv
// Scoreboard bench for axi_arbiter_rd: stimulus queues expected output snapshots with
// their cycle stamps; a monitor compares every change of the output snapshot.
module tb_axi_arbiter_rd;

    logic ACLK = 1'b0;
    logic ARESET = 1'b0;
    logic m0_ARVALID = 1'b0, m1_ARVALID = 1'b0, m2_ARVALID = 1'b0, m3_ARVALID = 1'b0;
    logic m0_RREADY = 1'b1, m1_RREADY = 1'b1, m2_RREADY = 1'b1, m3_RREADY = 1'b1;
    logic ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b0;
    logic m0_rgrnt, m1_rgrnt, m2_rgrnt, m3_rgrnt;
    logic [1:0] rgrnt_id;
    logic busy, timeout;

    axi_arbiter_rd #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m0_ARVALID(m0_ARVALID), .m1_ARVALID(m1_ARVALID),
        .m2_ARVALID(m2_ARVALID), .m3_ARVALID(m3_ARVALID),
        .m0_RREADY(m0_RREADY), .m1_RREADY(m1_RREADY),
        .m2_RREADY(m2_RREADY), .m3_RREADY(m3_RREADY),
        .ARREADY(ARREADY), .RVALID(RVALID), .RLAST(RLAST),
        .m0_rgrnt(m0_rgrnt), .m1_rgrnt(m1_rgrnt), .m2_rgrnt(m2_rgrnt), .m3_rgrnt(m3_rgrnt),
        .rgrnt_id(rgrnt_id), .busy(busy), .timeout(timeout)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int         cyc;
        logic [7:0] snap;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] prev_snap = 8'h00;

    // Monitor: one-hot check every cycle, scoreboard compare on every snapshot change.
    always @(posedge ACLK) begin
        logic [3:0] gv;
        logic [7:0] snap;
        exp_t       e;
        cyc = cyc + 1;
        #1;
        gv   = {m3_rgrnt, m2_rgrnt, m1_rgrnt, m0_rgrnt};
        snap = {gv, rgrnt_id, busy, timeout};
        if ((gv & (gv - 4'd1)) != 4'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL onehot cyc=%0d grant=%b required one-hot or zero", cyc, gv);
        end
        if (snap != prev_snap) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected cyc=%0d got grant/id/busy/to=%b required no change", cyc, snap);
            end else begin
                e = exp_q.pop_front();
                if (e.snap != snap || e.cyc != cyc) begin
                    n_bad = n_bad + 1;
                    $display("FAIL snapshot got cyc=%0d grant/id/busy/to=%b required cyc=%0d %b",
                             cyc, snap, e.cyc, e.snap);
                end
            end
        end
        prev_snap = snap;
    end

    // Reset must clear grants and busy without waiting for a clock edge.
    always @(posedge ARESET) begin
        #1;
        n_vec = n_vec + 1;
        if ({m3_rgrnt, m2_rgrnt, m1_rgrnt, m0_rgrnt, rgrnt_id, busy, timeout} != 8'h00) begin
            n_bad = n_bad + 1;
            $display("FAIL async_reset got %b required 00000000",
                     {m3_rgrnt, m2_rgrnt, m1_rgrnt, m0_rgrnt, rgrnt_id, busy, timeout});
        end
    end

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic expect_at(input int dc, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic t);
        exp_t e;
        e.cyc  = cyc + dc;
        e.snap = {g, id, b, t};
        exp_q.push_back(e);
    endtask

    task automatic set_arvalid(input int id, input logic v);
        case (id)
            0: m0_ARVALID = v;
            1: m1_ARVALID = v;
            2: m2_ARVALID = v;
            3: m3_ARVALID = v;
            default: ;
        endcase
    endtask

    // Run one burst from ADDR: AR handshake, nb beats with RLAST on the last; the
    // snapshot after the last beat is given by the caller.
    task automatic burst(input int drop_id, input int nb, input logic [3:0] ng,
                         input logic [1:0] nid, input logic nbusy);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        set_arvalid(drop_id, 1'b0);
        for (int b = 1; b <= nb; b++) begin
            RVALID = 1'b1;
            RLAST  = (b == nb);
            if (b == nb) expect_at(1, ng, nid, nbusy, 1'b0);
            tick();
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
    endtask

    initial begin
        #3 ARESET = 1'b1;
        tick(); tick();
        ARESET = 1'b0;
        tick();

        // Single request from m2, 4-beat burst, release leaves ptr=3.
        m2_ARVALID = 1'b1;
        expect_at(1, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        burst(2, 4, 4'b0000, 2'd2, 1'b0);
        // ptr=3 means m3 beats m0; then m0 follows back-to-back.
        m0_ARVALID = 1'b1;
        m3_ARVALID = 1'b1;
        expect_at(1, 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        burst(3, 1, 4'b0001, 2'd0, 1'b1);
        burst(0, 2, 4'b0000, 2'd0, 1'b0);

        // Reset mid-burst (m1, DATA after beat 2 of 8).
        m1_ARVALID = 1'b1;
        expect_at(1, 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        ARREADY = 1'b1;
        tick();
        ARREADY    = 1'b0;
        m1_ARVALID = 1'b0;
        RVALID     = 1'b1;
        tick(); tick();
        ARESET = 1'b1;
        expect_at(1, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        ARESET = 1'b0;
        RVALID = 1'b0;
        tick();

        // All four requesting: strict rotation from m0, back-to-back handovers.
        {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID} = 4'b1111;
        expect_at(1, 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        burst(-1, 2, 4'b0010, 2'd1, 1'b1);
        burst(-1, 2, 4'b0100, 2'd2, 1'b1);
        burst(-1, 2, 4'b1000, 2'd3, 1'b1);
        burst(-1, 2, 4'b0001, 2'd0, 1'b1);
        {m3_ARVALID, m2_ARVALID, m1_ARVALID} = 3'b000;
        burst(0, 2, 4'b0000, 2'd0, 1'b0);

        // m1 alone twice: one IDLE dead cycle between the two grants.
        m1_ARVALID = 1'b1;
        expect_at(1, 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        burst(-1, 1, 4'b0000, 2'd1, 1'b0);
        expect_at(1, 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        burst(1, 1, 4'b0000, 2'd1, 1'b0);

        // Watchdog: m0 withdraws ARVALID in ADDR, ARREADY held low; m3 pending.
        m0_ARVALID = 1'b1;
        expect_at(1, 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        m0_ARVALID = 1'b0;
        m3_ARVALID = 1'b1;
        expect_at(8, 4'b0000, 2'd0, 1'b0, 1'b1);
        expect_at(9, 4'b1000, 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        burst(3, 1, 4'b0000, 2'd3, 1'b0);

        // R beat in ADDR is ignored; then last beat lands on the expiry cycle.
        m2_ARVALID = 1'b1;
        expect_at(1, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        RVALID = 1'b1;
        RLAST  = 1'b1;
        tick();
        RVALID = 1'b0;
        RLAST  = 1'b0;
        ARREADY = 1'b1;
        tick();
        ARREADY    = 1'b0;
        m2_ARVALID = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        RVALID = 1'b1;
        RLAST  = 1'b1;
        expect_at(1, 4'b0000, 2'd2, 1'b0, 1'b0);
        tick();
        RVALID = 1'b0;
        RLAST  = 1'b0;

        for (int i = 0; i < 4; i++) tick();
        n_vec = n_vec + 1;
        if (exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
